pms_stage: RTL and testbench

- Pre-memory pipeline stage, directly downstream of the execute stage and upstream of the memory stage.
- Latches the execute-stage result for the memory-issuing slot of the dual-issue pair, checks load/store alignment, and issues the data-SRAM request with an SRAM-like req/addr_ok handshake.
- Owns the architectural HI/LO registers, written from the 1-cycle-latency multiplier product, the divider {quotient, remainder}, or rs (MTHI/MTLO).
- Forwards everything to the memory stage with valid/allowin flow control.

---
 rtl/pms_stage_if.sv | 22 ++
 rtl/pms_stage.sv | 217 +++++++++++++++++++++
 tb/tb_pms_stage.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pms_stage_if.sv
// Data-SRAM request channel between the pre-memory stage and the data SRAM.
//   req/wr/size/addr/wstrb/wdata : request driven by the stage (master)
//   addr_ok                      : request accepted, driven by the SRAM side (slave)
interface pms_stage_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok
  );
endinterface

// File: rtl/pms_stage.sv
// Pre-memory pipeline stage (execute -> pre-memory -> memory).
// Latches the memory-slot result of the issue pair, checks load/store alignment,
// issues the data-SRAM request (req/addr_ok) and owns the HI/LO registers.
// Ports:
//   clk, resetn                      : clock, asynchronous active-low reset
//   es_to_pms_valid / pms_allowin    : upstream handshake
//   pms_to_ms_valid / ms_allowin     : downstream handshake
//   es_mem_* / es_except             : memory access of the pair, upstream exception
//   es_hi_we/es_lo_we/es_hl_src/...  : HI/LO write controls and sources
//   es_mul_res                       : multiplier product, sampled live while the pair is held
//   clear_all                        : pipeline flush
//   data_sram                        : SRAM request channel (master side)
//   pms_adel/pms_ades/pms_badvaddr   : address error report
//   pms_req_issued                   : SRAM accepted the request of the current pair
//   hi_value/lo_value                : architectural HI/LO
// Optional feature: define PMS_HILO_BYPASS_EN to forward the HI/LO value being
// written in the firing cycle onto hi_value/lo_value.
module pms_stage #(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_pms_valid,
  output logic        pms_allowin,
  input  logic        ms_allowin,
  output logic        pms_to_ms_valid,
  input  logic        es_mem_op,
  input  logic        es_mem_we,
  input  logic [1:0]  es_mem_size,
  input  logic [31:0] es_mem_addr,
  input  logic [31:0] es_mem_wdata,
  input  logic        es_except,
  input  logic        es_hi_we,
  input  logic        es_lo_we,
  input  logic [1:0]  es_hl_src,
  input  logic [31:0] es_hl_rs,
  input  logic [63:0] es_div_res,
  input  logic [63:0] es_mul_res,
  input  logic        clear_all,
  pms_stage_if.master data_sram,
  output logic        pms_adel,
  output logic        pms_ades,
  output logic [31:0] pms_badvaddr,
  output logic        pms_req_issued,
  output logic [31:0] hi_value,
  output logic [31:0] lo_value
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        first_q;
  logic        cancel_q, cancel_d;
  logic        mem_op_q, mem_we_q, except_q, hi_we_q, lo_we_q;
  logic [1:0]  size_q, hl_src_q;
  logic [31:0] addr_q, wdata_q, hl_rs_q;
  logic [63:0] div_q;
  logic [31:0] hi_q, lo_q, hi_new, lo_new;

  logic misalign, mis_err, no_req, issue, mul_hold, ready_go, req;
  logic cancel_pend, capture, fire, hl_wr;
  logic [3:0]  strb_raw;
  logic [31:0] wdata_rep;

  assign misalign = ((size_q == 2'd1) & addr_q[0]) | ((size_q == 2'd2) & (addr_q[1:0] != 2'b00));
  assign mis_err  = mem_op_q & misalign;
  assign no_req   = !mem_op_q | misalign | except_q;
  assign issue    = valid_q & mem_op_q & !misalign & !except_q & !clear_all;
  // Product arrives one cycle after entry, so a multiply pair never leaves in its entry cycle.
  assign mul_hold = valid_q & first_q & (hl_src_q == 2'd1);

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    req      = 1'b0;
    ready_go = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_go = no_req;
        if (issue) begin
          req     = 1'b1;
          state_d = data_sram.addr_ok ? StDone : StReq;
        end
      end
      StReq: begin
        // A flushed request is never retracted; it completes and is then dropped.
        req = 1'b1;
        if (data_sram.addr_ok) begin
          state_d  = (cancel_q | clear_all) ? StIdle : StDone;
          cancel_d = 1'b0;
        end else if (clear_all) begin
          cancel_d = 1'b1;
        end
      end
      StDone: begin
        ready_go = 1'b1;
        if (clear_all | (ms_allowin & !mul_hold)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (mul_hold) ready_go = 1'b0;
  end

  assign cancel_pend     = (state_q == StReq) & cancel_q;
  // Gated by resetn so that every output reads 0 while reset is held.
  assign pms_allowin     = resetn & !cancel_pend & (!valid_q | (ready_go & ms_allowin));
  assign pms_to_ms_valid = valid_q & ready_go & !clear_all;
  assign fire            = pms_to_ms_valid & ms_allowin;
  assign capture         = es_to_pms_valid & pms_allowin & !clear_all;
  assign hl_wr           = fire & !except_q & !mis_err;

  always_comb begin
    valid_d = valid_q;
    if (clear_all)        valid_d = 1'b0;
    else if (pms_allowin) valid_d = es_to_pms_valid;
  end

  always_comb begin
    strb_raw  = 4'b1111;
    wdata_rep = wdata_q;
    case (size_q)
      2'd0: begin
        strb_raw  = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        strb_raw  = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    hi_new = hl_rs_q;
    lo_new = hl_rs_q;
    case (hl_src_q)
      2'd1: begin
        hi_new = es_mul_res[63:32];
        lo_new = es_mul_res[31:0];
      end
      2'd2: begin
        lo_new = div_q[63:32];
        hi_new = div_q[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      cancel_q <= 1'b0;
      hi_q     <= HILO_RST;
      lo_q     <= HILO_RST;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      first_q  <= capture;
      cancel_q <= cancel_d;
      if (hl_wr & hi_we_q) hi_q <= hi_new;
      if (hl_wr & lo_we_q) lo_q <= lo_new;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_op_q <= 1'b0;
      mem_we_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      except_q <= 1'b0;
      hi_we_q  <= 1'b0;
      lo_we_q  <= 1'b0;
      hl_src_q <= 2'd0;
      hl_rs_q  <= 32'h0;
      div_q    <= 64'h0;
    end else if (capture) begin
      mem_op_q <= es_mem_op;
      mem_we_q <= es_mem_we;
      size_q   <= es_mem_size;
      addr_q   <= es_mem_addr;
      wdata_q  <= es_mem_wdata;
      except_q <= es_except;
      hi_we_q  <= es_hi_we;
      lo_we_q  <= es_lo_we;
      hl_src_q <= es_hl_src;
      hl_rs_q  <= es_hl_rs;
      div_q    <= es_div_res;
    end
  end

  assign data_sram.req   = req;
  assign data_sram.wr    = mem_op_q & mem_we_q;
  assign data_sram.size  = size_q;
  assign data_sram.addr  = addr_q;
  assign data_sram.wstrb = (mem_op_q & mem_we_q) ? strb_raw : 4'b0000;
  assign data_sram.wdata = wdata_rep;

  assign pms_adel       = valid_q & mis_err & !mem_we_q;
  assign pms_ades       = valid_q & mis_err & mem_we_q;
  assign pms_badvaddr   = (valid_q & mis_err) ? addr_q : 32'h0;
  assign pms_req_issued = valid_q & (state_q == StDone);

`ifdef PMS_HILO_BYPASS_EN
  assign hi_value = (hl_wr & hi_we_q) ? hi_new : hi_q;
  assign lo_value = (hl_wr & lo_we_q) ? lo_new : lo_q;
`else
  assign hi_value = hi_q;
  assign lo_value = lo_q;
`endif

endmodule

// File: tb/tb_pms_stage.sv
module tb_pms_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_pms_valid, pms_allowin, ms_allowin, pms_to_ms_valid;
  logic        es_mem_op, es_mem_we, es_except, es_hi_we, es_lo_we, clear_all;
  logic [1:0]  es_mem_size, es_hl_src;
  logic [31:0] es_mem_addr, es_mem_wdata, es_hl_rs;
  logic [63:0] es_div_res, es_mul_res;
  logic        pms_adel, pms_ades, pms_req_issued;
  logic [31:0] pms_badvaddr, hi_value, lo_value;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_hi, model_lo;

  always #5 clk = ~clk;

  pms_stage_if data_sram ();

  pms_stage #(.HILO_RST(32'h0)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_pms_valid(es_to_pms_valid), .pms_allowin(pms_allowin),
    .ms_allowin(ms_allowin), .pms_to_ms_valid(pms_to_ms_valid),
    .es_mem_op(es_mem_op), .es_mem_we(es_mem_we), .es_mem_size(es_mem_size),
    .es_mem_addr(es_mem_addr), .es_mem_wdata(es_mem_wdata), .es_except(es_except),
    .es_hi_we(es_hi_we), .es_lo_we(es_lo_we), .es_hl_src(es_hl_src), .es_hl_rs(es_hl_rs),
    .es_div_res(es_div_res), .es_mul_res(es_mul_res), .clear_all(clear_all),
    .data_sram(data_sram),
    .pms_adel(pms_adel), .pms_ades(pms_ades), .pms_badvaddr(pms_badvaddr),
    .pms_req_issued(pms_req_issued), .hi_value(hi_value), .lo_value(lo_value)
  );

  typedef struct {
    logic mem_op; logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;
    logic except; logic hi_we; logic lo_we; logic [1:0] src; logic [31:0] rs;
    logic [63:0] div; logic [63:0] mul;
  } pair_t;

  typedef struct {
    int req_cycles; bit stable; logic [3:0] wstrb; logic [31:0] wdata; logic [31:0] addr;
    logic wr; logic adel; logic ades; logic [31:0] badv; bit fired; logic issued;
    int fire_cyc; bit valid_held; bit hl_early_ok;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int unsigned m_bytes(pair_t p);
    return 32'd1 << p.size;
  endfunction

  function automatic bit m_mis(pair_t p);
    return p.mem_op && ((p.addr % m_bytes(p)) != 0);
  endfunction

  function automatic bit m_req(pair_t p);
    return p.mem_op && !m_mis(p) && !p.except;
  endfunction

  function automatic logic [3:0] m_wstrb(pair_t p);
    int unsigned mask;
    logic [3:0] r;
    mask = ((32'd1 << m_bytes(p)) - 1) << (p.addr % 4);
    r = mask[3:0];
    return p.we ? r : 4'b0000;
  endfunction

  function automatic logic [31:0] m_wdata(pair_t p);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = p.wdata[(i % m_bytes(p))*8 +: 8];
    return r;
  endfunction

  task automatic m_commit(input pair_t p);
    logic [31:0] h, l;
    if (p.except || m_mis(p)) return;
    h = p.rs; l = p.rs;
    if (p.src == 2'd1) begin h = p.mul[63:32]; l = p.mul[31:0]; end
    if (p.src == 2'd2) begin l = p.div[63:32]; h = p.div[31:0]; end
    if (p.hi_we) model_hi = h;
    if (p.lo_we) model_lo = l;
  endtask

  function automatic pair_t blank();
    pair_t p;
    p = '{default: 0};
    return p;
  endfunction

  // Drives one pair through the stage and records what the DUT did (no judging here).
  task automatic drive_pair(input pair_t p, input int ok_delay, input int stall, output obs_t o);
    int cyc, vcount;
    o = '{default: 0};
    o.stable = 1; o.valid_held = 1; o.hl_early_ok = 1;
    @(posedge clk); #1;
    ms_allowin = 0; data_sram.addr_ok = 0;
    es_to_pms_valid = 1; es_mem_op = p.mem_op; es_mem_we = p.we; es_mem_size = p.size;
    es_mem_addr = p.addr; es_mem_wdata = p.wdata; es_except = p.except;
    es_hi_we = p.hi_we; es_lo_we = p.lo_we; es_hl_src = p.src; es_hl_rs = p.rs;
    es_div_res = p.div; es_mul_res = ~p.mul;
    @(posedge clk); #1;
    es_to_pms_valid = 0; es_mem_addr = $urandom; es_mem_wdata = $urandom;
    es_hl_rs = $urandom; es_div_res = {$urandom, $urandom}; es_mem_size = 2'($urandom_range(0, 2));
    es_mem_we = 1'($urandom); es_hl_src = 2'($urandom_range(0, 2));
    cyc = 0; vcount = 0;
    while (!o.fired && cyc < 60) begin
      ms_allowin = 0; data_sram.addr_ok = 0;
      @(negedge clk); cyc++;
      if (cyc == 2) es_mul_res = p.mul;
      if (cyc == 1) begin o.adel = pms_adel; o.ades = pms_ades; o.badv = pms_badvaddr; end
      if (hi_value !== model_hi || lo_value !== model_lo) o.hl_early_ok = 0;
      if (data_sram.req === 1'b1) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.wstrb = data_sram.wstrb; o.wdata = data_sram.wdata;
          o.addr = data_sram.addr; o.wr = data_sram.wr;
        end else if (o.wstrb !== data_sram.wstrb || o.wdata !== data_sram.wdata ||
                     o.addr !== data_sram.addr || o.wr !== data_sram.wr) begin
          o.stable = 0;
        end
        data_sram.addr_ok = (o.req_cycles == ok_delay + 1);
      end
      if (pms_to_ms_valid === 1'b1) begin
        if (vcount < stall) vcount++;
        else begin
          ms_allowin = 1; o.fired = 1; o.issued = pms_req_issued; o.fire_cyc = cyc;
        end
      end else if (vcount > 0) o.valid_held = 0;
      @(posedge clk); #1;
    end
    ms_allowin = 0; data_sram.addr_ok = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetn = 0;
    es_to_pms_valid = 0; ms_allowin = 0; es_mem_op = 0; es_mem_we = 0; es_mem_size = 0;
    es_mem_addr = 0; es_mem_wdata = 0; es_except = 0; es_hi_we = 0; es_lo_we = 0;
    es_hl_src = 0; es_hl_rs = 0; es_div_res = 0; es_mul_res = 0; clear_all = 0;
    data_sram.addr_ok = 0;
    model_hi = 32'h0; model_lo = 32'h0;
    #12; @(negedge clk);
    n_checks++;
    if ({pms_allowin, pms_to_ms_valid, data_sram.req, data_sram.wr, pms_adel, pms_ades,
         pms_req_issued} !== 7'b0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b want 0000000", {pms_allowin, pms_to_ms_valid,
        data_sram.req, data_sram.wr, pms_adel, pms_ades, pms_req_issued});
    end
    n_checks++;
    if ({data_sram.addr, data_sram.wdata, data_sram.wstrb, data_sram.size, pms_badvaddr} !== '0) begin
      n_errors++; $display("FAIL reset_bus: addr %h wdata %h wstrb %b badv %h want all 0",
        data_sram.addr, data_sram.wdata, data_sram.wstrb, pms_badvaddr);
    end
    n_checks++;
    if (hi_value !== 32'h0 || lo_value !== 32'h0) begin
      n_errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_value, lo_value);
    end
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    n_checks++;
    if (pms_allowin !== 1'b1) begin
      n_errors++; $display("FAIL reset_allowin: got %b want 1", pms_allowin);
    end
  endtask

  task automatic test_store_word;
    pair_t p; obs_t o;
    p = blank(); p.mem_op = 1; p.we = 1; p.size = 2; p.addr = 32'h8000_0004; p.wdata = 32'h1122_3344;
    drive_pair(p, 2, 0, o); m_commit(p);
    n_checks++; if (o.req_cycles != 3) begin n_errors++; $display("FAIL sw_req_len: got %0d want 3", o.req_cycles); end
    n_checks++; if (!o.stable) begin n_errors++; $display("FAIL sw_stable: got 0 want 1"); end
    n_checks++; if (o.wstrb !== 4'b1111 || o.wdata !== 32'h1122_3344 || o.addr !== 32'h8000_0004 || o.wr !== 1'b1) begin
      n_errors++; $display("FAIL sw_fields: wstrb %b wdata %h addr %h wr %b want 1111 11223344 80000004 1", o.wstrb, o.wdata, o.addr, o.wr); end
    n_checks++; if (!o.fired || o.issued !== 1'b1) begin n_errors++; $display("FAIL sw_fire: fired %0d issued %b want 1 1", o.fired, o.issued); end
  endtask

  task automatic test_store_byte;
    pair_t p; obs_t o;
    p = blank(); p.mem_op = 1; p.we = 1; p.size = 0; p.addr = 32'h8000_0003; p.wdata = 32'h0000_00AB;
    drive_pair(p, 0, 0, o); m_commit(p);
    n_checks++; if (o.wstrb !== 4'b1000 || o.wdata !== 32'hABAB_ABAB) begin
      n_errors++; $display("FAIL sb_fields: wstrb %b wdata %h want 1000 ababab ab", o.wstrb, o.wdata); end
    n_checks++; if (o.req_cycles != 1 || !o.fired) begin
      n_errors++; $display("FAIL sb_flow: req %0d fired %0d want 1 1", o.req_cycles, o.fired); end
  endtask

  task automatic test_load_misaligned;
    pair_t p; obs_t o;
    p = blank(); p.mem_op = 1; p.we = 0; p.size = 1; p.addr = 32'h8000_0001;
    p.hi_we = 1; p.lo_we = 1; p.rs = 32'hDEAD_BEEF;
    drive_pair(p, 0, 0, o); m_commit(p);
    n_checks++; if (o.req_cycles != 0) begin n_errors++; $display("FAIL lh_noreq: got %0d want 0", o.req_cycles); end
    n_checks++; if (o.adel !== 1'b1 || o.ades !== 1'b0 || o.badv !== 32'h8000_0001) begin
      n_errors++; $display("FAIL lh_adel: adel %b ades %b badv %h want 1 0 80000001", o.adel, o.ades, o.badv); end
    n_checks++; if (o.fire_cyc != 1) begin n_errors++; $display("FAIL lh_ready: got cycle %0d want 1", o.fire_cyc); end
    @(negedge clk);
    n_checks++; if (hi_value !== model_hi || lo_value !== model_lo) begin
      n_errors++; $display("FAIL lh_hilo: got %h/%h want %h/%h", hi_value, lo_value, model_hi, model_lo); end
  endtask

  task automatic test_mult;
    pair_t p; obs_t o;
    p = blank(); p.hi_we = 1; p.lo_we = 1; p.src = 1; p.mul = 64'hFFFF_FFFF_0000_0002;
    drive_pair(p, 0, 0, o); m_commit(p);
    n_checks++; if (o.fire_cyc != 2) begin n_errors++; $display("FAIL mult_hold: fire cycle %0d want 2", o.fire_cyc); end
    @(negedge clk);
    n_checks++; if (hi_value !== 32'hFFFF_FFFF || lo_value !== 32'h2) begin
      n_errors++; $display("FAIL mult_hilo: got %h/%h want ffffffff/00000002", hi_value, lo_value); end
  endtask

  task automatic test_div_stall;
    pair_t p; obs_t o;
    p = blank(); p.hi_we = 1; p.lo_we = 1; p.src = 2; p.div = {32'h7, 32'h3};
    drive_pair(p, 0, 3, o);
    n_checks++; if (!o.valid_held || o.fire_cyc != 4) begin
      n_errors++; $display("FAIL div_stall: held %0d fire cycle %0d want 1 4", o.valid_held, o.fire_cyc); end
    n_checks++; if (!o.hl_early_ok) begin n_errors++; $display("FAIL div_early: HI/LO changed before fire, want unchanged"); end
    m_commit(p);
    @(negedge clk);
    n_checks++; if (hi_value !== 32'h3 || lo_value !== 32'h7) begin
      n_errors++; $display("FAIL div_hilo: got %h/%h want 00000003/00000007", hi_value, lo_value); end
  endtask

  task automatic test_clear_in_req;
    bit seen_valid;
    @(posedge clk); #1;
    ms_allowin = 1; data_sram.addr_ok = 0; es_to_pms_valid = 1;
    es_mem_op = 1; es_mem_we = 0; es_mem_size = 2; es_mem_addr = 32'h8000_0010; es_except = 0;
    es_hi_we = 1; es_lo_we = 0; es_hl_src = 0; es_hl_rs = 32'h5555_AAAA;
    @(posedge clk); #1 es_to_pms_valid = 0;
    @(negedge clk); seen_valid = pms_to_ms_valid;
    n_checks++; if (data_sram.req !== 1'b1) begin n_errors++; $display("FAIL clr_issue: req %b want 1", data_sram.req); end
    @(posedge clk); #1 clear_all = 1;
    @(negedge clk); seen_valid |= pms_to_ms_valid;
    n_checks++; if (data_sram.req !== 1'b1 || pms_allowin !== 1'b0) begin
      n_errors++; $display("FAIL clr_pulse: req %b allowin %b want 1 0", data_sram.req, pms_allowin); end
    @(posedge clk); #1 clear_all = 0;
    @(negedge clk); seen_valid |= pms_to_ms_valid;
    n_checks++; if (data_sram.req !== 1'b1 || pms_allowin !== 1'b0) begin
      n_errors++; $display("FAIL clr_pending: req %b allowin %b want 1 0", data_sram.req, pms_allowin); end
    @(posedge clk); #1 data_sram.addr_ok = 1;
    @(negedge clk); seen_valid |= pms_to_ms_valid;
    @(posedge clk); #1 data_sram.addr_ok = 0;
    @(negedge clk); seen_valid |= pms_to_ms_valid;
    n_checks++; if (data_sram.req !== 1'b0 || pms_allowin !== 1'b1 || pms_req_issued !== 1'b0) begin
      n_errors++; $display("FAIL clr_idle: req %b allowin %b issued %b want 0 1 0", data_sram.req, pms_allowin, pms_req_issued); end
    n_checks++; if (seen_valid || hi_value !== model_hi) begin
      n_errors++; $display("FAIL clr_nofire: fired %b hi %h want 0 %h", seen_valid, hi_value, model_hi); end
    ms_allowin = 0;
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    ms_allowin = 1; es_to_pms_valid = 1; es_mem_op = 0; es_except = 0; es_hl_src = 0;
    es_hi_we = 1; es_lo_we = 0; es_hl_rs = 32'h0A0A_0001;
    @(posedge clk); #1;
    es_hi_we = 0; es_lo_we = 1; es_hl_rs = 32'h0B0B_0002;
    @(negedge clk);
    n_checks++; if (pms_to_ms_valid !== 1'b1 || pms_allowin !== 1'b1) begin
      n_errors++; $display("FAIL b2b_first: valid %b allowin %b want 1 1", pms_to_ms_valid, pms_allowin); end
    @(posedge clk); #1 es_to_pms_valid = 0;
    model_hi = 32'h0A0A_0001;
    @(negedge clk);
    n_checks++; if (pms_to_ms_valid !== 1'b1 || hi_value !== 32'h0A0A_0001) begin
      n_errors++; $display("FAIL b2b_second: valid %b hi %h want 1 0a0a0001", pms_to_ms_valid, hi_value); end
    @(posedge clk); #1 ms_allowin = 0;
    model_lo = 32'h0B0B_0002;
    @(negedge clk);
    n_checks++; if (pms_to_ms_valid !== 1'b0 || lo_value !== 32'h0B0B_0002 || hi_value !== 32'h0A0A_0001) begin
      n_errors++; $display("FAIL b2b_done: valid %b hi %h lo %h want 0 0a0a0001 0b0b0002", pms_to_ms_valid, hi_value, lo_value); end
  endtask

  task automatic test_random;
    pair_t p; obs_t o; int d; bit er;
    for (int i = 0; i < 40; i++) begin
      p = blank();
      p.mem_op = 1'($urandom); p.we = 1'($urandom); p.size = 2'($urandom_range(0, 2));
      p.addr = $urandom; p.wdata = $urandom; p.except = ($urandom_range(0, 7) == 0);
      p.hi_we = 1'($urandom); p.lo_we = 1'($urandom); p.src = 2'($urandom_range(0, 2));
      p.rs = $urandom; p.div = {$urandom, $urandom}; p.mul = {$urandom, $urandom};
      d = $urandom_range(0, 3);
      drive_pair(p, d, $urandom_range(0, 2), o);
      m_commit(p);
      er = m_req(p);
      n_checks++; if (!o.fired) begin n_errors++; $display("FAIL rnd%0d_fire: no fire within budget", i); end
      n_checks++; if (o.req_cycles != (er ? d + 1 : 0)) begin
        n_errors++; $display("FAIL rnd%0d_reqlen: got %0d want %0d", i, o.req_cycles, er ? d + 1 : 0); end
      if (er) begin
        n_checks++; if (o.wstrb !== m_wstrb(p) || o.wdata !== m_wdata(p) || o.addr !== p.addr || o.wr !== p.we || !o.stable) begin
          n_errors++; $display("FAIL rnd%0d_bus: wstrb %b wdata %h addr %h wr %b stable %0d want %b %h %h %b 1",
            i, o.wstrb, o.wdata, o.addr, o.wr, o.stable, m_wstrb(p), m_wdata(p), p.addr, p.we); end
      end
      n_checks++; if (o.issued !== er) begin n_errors++; $display("FAIL rnd%0d_issued: got %b want %b", i, o.issued, er); end
      n_checks++; if (o.adel !== (m_mis(p) && !p.we) || o.ades !== (m_mis(p) && p.we) || o.badv !== (m_mis(p) ? p.addr : 32'h0)) begin
        n_errors++; $display("FAIL rnd%0d_aderr: adel %b ades %b badv %h want %b %b %h", i, o.adel, o.ades, o.badv,
          m_mis(p) && !p.we, m_mis(p) && p.we, m_mis(p) ? p.addr : 32'h0); end
      @(negedge clk);
      n_checks++; if (hi_value !== model_hi || lo_value !== model_lo) begin
        n_errors++; $display("FAIL rnd%0d_hilo: got %h/%h want %h/%h", i, hi_value, lo_value, model_hi, model_lo); end
    end
  endtask

  task automatic test_reset_mid_req;
    @(posedge clk); #1;
    es_to_pms_valid = 1; es_mem_op = 1; es_mem_we = 1; es_mem_size = 2; es_mem_addr = 32'h8000_0020;
    es_except = 0; es_hi_we = 0; es_lo_we = 0;
    @(posedge clk); #1 es_to_pms_valid = 0;
    @(negedge clk);
    n_checks++; if (data_sram.req !== 1'b1) begin n_errors++; $display("FAIL rstreq_pre: req %b want 1", data_sram.req); end
    #1 resetn = 0;
    #1;
    n_checks++; if (data_sram.req !== 1'b0 || hi_value !== 32'h0 || lo_value !== 32'h0) begin
      n_errors++; $display("FAIL rstreq_drop: req %b hi %h lo %h want 0 0 0", data_sram.req, hi_value, lo_value); end
    model_hi = 32'h0; model_lo = 32'h0;
    @(posedge clk); #1 resetn = 1;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_misaligned();
    test_mult();
    test_div_stall();
    test_clear_in_req();
    test_back_to_back();
    test_random();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
